// File: rtl/rob_if.sv
// rtl/rob_if.sv - ROB issue / writeback / lookup / commit signal bundle
interface rob_if #(
  parameter int ROB_BIT = 4
);
  logic               rdy;

  logic               issue_valid;
  logic [1:0]         issue_type;
  logic [4:0]         issue_rd;
  logic               issue_pred_taken;
  logic [31:0]        issue_alt_pc;
  logic [ROB_BIT-1:0] issue_rob_id;
  logic               rob_full;

  logic               alu_ready;
  logic [ROB_BIT-1:0] alu_rob_id;
  logic [31:0]        alu_value;
  logic               alu_taken;

  logic               lsb_ready;
  logic [ROB_BIT-1:0] lsb_rob_id;
  logic [31:0]        lsb_value;

  logic [ROB_BIT-1:0] q1_id;
  logic [ROB_BIT-1:0] q2_id;
  logic               q1_ready;
  logic               q2_ready;
  logic [31:0]        q1_value;
  logic [31:0]        q2_value;

  logic               commit_valid;
  logic [4:0]         commit_rd;
  logic [31:0]        commit_value;
  logic [ROB_BIT-1:0] commit_rob_id;
  logic               store_commit;
  logic               flush;
  logic [31:0]        flush_pc;

  // ROB side
  modport slave (
    input  rdy,
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output issue_rob_id, rob_full,
    input  alu_ready, alu_rob_id, alu_value, alu_taken,
    input  lsb_ready, lsb_rob_id, lsb_value,
    input  q1_id, q2_id,
    output q1_ready, q2_ready, q1_value, q2_value,
    output commit_valid, commit_rd, commit_value, commit_rob_id,
    output store_commit, flush, flush_pc
  );

  // Decoder / execution units / register file side
  modport master (
    output rdy,
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  issue_rob_id, rob_full,
    output alu_ready, alu_rob_id, alu_value, alu_taken,
    output lsb_ready, lsb_rob_id, lsb_value,
    output q1_id, q2_id,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  commit_valid, commit_rd, commit_value, commit_rob_id,
    input  store_commit, flush, flush_pc
  );
endinterface

// File: rtl/rob.sv
// rtl/rob.sv - circular reorder buffer with in-order retire and mispredict flush
module rob #(
  parameter int ROB_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  rob_if.slave bus
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam int CNT_W = ROB_BIT + 1;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;

  // Per-entry control flags (reset) and payload (no reset needed)
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] taken;
  logic [DEPTH-1:0] pred;
  logic [1:0]       typ    [DEPTH];
  logic [4:0]       rd     [DEPTH];
  logic [31:0]      value  [DEPTH];
  logic [31:0]      alt_pc [DEPTH];

  logic [ROB_BIT-1:0] head;
  logic [ROB_BIT-1:0] tail;
  logic [CNT_W-1:0]   count;

  logic full;
  logic retire;
  logic mispredict;
  logic advance;
  logic alloc;
  logic alu_wr;
  logic lsb_wr;

  logic [ROB_BIT-1:0] q_id  [2];
  logic               q_rdy [2];
  logic [31:0]        q_val [2];

  assign full             = (count == CNT_W'(DEPTH));
  assign bus.rob_full     = full;
  assign bus.issue_rob_id = tail;

  // Retirement looks only at registered flags, so a writeback to the head
  // entry retires it one cycle later rather than in the same cycle.
  assign retire     = bus.rdy && busy[head] && ready[head];
  assign mispredict = retire && (typ[head] == T_BRANCH) && (taken[head] != pred[head]);

  // A mispredict wipes the buffer, so same-cycle issue and writeback are dropped.
  assign advance = !rst && bus.rdy && !mispredict;
  // A full buffer still accepts an issue when the head frees a slot this cycle.
  assign alloc   = advance && bus.issue_valid && (!full || retire);
  assign alu_wr  = advance && bus.alu_ready && busy[bus.alu_rob_id];
  assign lsb_wr  = advance && bus.lsb_ready && busy[bus.lsb_rob_id];

  assign q_id[0]      = bus.q1_id;
  assign q_id[1]      = bus.q2_id;
  assign bus.q1_ready = q_rdy[0];
  assign bus.q1_value = q_val[0];
  assign bus.q2_ready = q_rdy[1];
  assign bus.q2_value = q_val[1];

  // Operand lookup: stored result first, then same-cycle broadcast (lsb over alu)
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_rdy[p] = 1'b0;
      q_val[p] = 32'd0;
      if (busy[q_id[p]] && ready[q_id[p]]) begin
        q_rdy[p] = 1'b1;
        q_val[p] = value[q_id[p]];
      end else if (bus.lsb_ready && (bus.lsb_rob_id == q_id[p])) begin
        q_rdy[p] = 1'b1;
        q_val[p] = bus.lsb_value;
      end else if (bus.alu_ready && (bus.alu_rob_id == q_id[p])) begin
        q_rdy[p] = 1'b1;
        q_val[p] = bus.alu_value;
      end
    end
  end

  // Entry payload: metadata on allocation, results on writeback (lsb written last so it wins)
  always_ff @(posedge clk) begin
    if (alloc) begin
      typ[tail]    <= (bus.issue_type == 2'd3) ? T_REG : bus.issue_type;
      rd[tail]     <= bus.issue_rd;
      pred[tail]   <= bus.issue_pred_taken;
      alt_pc[tail] <= bus.issue_alt_pc;
      taken[tail]  <= 1'b0;
    end
    if (alu_wr) begin
      value[bus.alu_rob_id] <= bus.alu_value;
      taken[bus.alu_rob_id] <= bus.alu_taken;
    end
    if (lsb_wr) begin
      value[bus.lsb_rob_id] <= bus.lsb_value;
    end
  end

  // Control state: flags, pointers, count and the registered commit/flush outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy              <= '0;
      ready             <= '0;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      bus.commit_valid  <= 1'b0;
      bus.commit_rd     <= 5'd0;
      bus.commit_value  <= 32'd0;
      bus.commit_rob_id <= '0;
      bus.store_commit  <= 1'b0;
      bus.flush         <= 1'b0;
      bus.flush_pc      <= 32'd0;
    end else if (!bus.rdy) begin
      bus.commit_valid <= 1'b0;
      bus.store_commit <= 1'b0;
      bus.flush        <= 1'b0;
    end else begin
      bus.commit_valid <= 1'b0;
      bus.store_commit <= 1'b0;
      bus.flush        <= 1'b0;

      if (retire) begin
        busy[head]        <= 1'b0;
        bus.commit_rob_id <= head;
        bus.commit_rd     <= rd[head];
        bus.commit_value  <= value[head];
        bus.commit_valid  <= (typ[head] == T_REG);
        bus.store_commit  <= (typ[head] == T_STORE);
      end

      if (mispredict) begin
        bus.flush    <= 1'b1;
        bus.flush_pc <= alt_pc[head];
        busy         <= '0;
        ready        <= '0;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
      end else begin
        if (alu_wr) ready[bus.alu_rob_id] <= 1'b1;
        if (lsb_wr) ready[bus.lsb_rob_id] <= 1'b1;
        if (alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + ROB_BIT'(1);
        end
        if (retire) head <= head + ROB_BIT'(1);
        case ({alloc, retire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - directed self-checking bench for rob
module tb_rob;
  localparam int ROB_BIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  rob_if #(.ROB_BIT(ROB_BIT)) bus ();

  rob #(.ROB_BIT(ROB_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy              = 1'b1;
    bus.issue_valid      = 1'b0;
    bus.issue_type       = 2'd0;
    bus.issue_rd         = 5'd0;
    bus.issue_pred_taken = 1'b0;
    bus.issue_alt_pc     = 32'd0;
    bus.alu_ready        = 1'b0;
    bus.alu_rob_id       = '0;
    bus.alu_value        = 32'd0;
    bus.alu_taken        = 1'b0;
    bus.lsb_ready        = 1'b0;
    bus.lsb_rob_id       = '0;
    bus.lsb_value        = 32'd0;
    bus.q1_id            = '0;
    bus.q2_id            = '0;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [4:0] r, input logic p, input logic [31:0] alt);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = t;
    bus.issue_rd         = r;
    bus.issue_pred_taken = p;
    bus.issue_alt_pc     = alt;
  endtask

  task automatic set_alu(input logic [ROB_BIT-1:0] id, input logic [31:0] v, input logic tk);
    bus.alu_ready  = 1'b1;
    bus.alu_rob_id = id;
    bus.alu_value  = v;
    bus.alu_taken  = tk;
  endtask

  task automatic set_lsb(input logic [ROB_BIT-1:0] id, input logic [31:0] v);
    bus.lsb_ready  = 1'b1;
    bus.lsb_rob_id = id;
    bus.lsb_value  = v;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_store_commit", bus.store_commit, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_flush_pc", bus.flush_pc, 0);
    check("rst_rob_full", bus.rob_full, 0);
    check("rst_tail", bus.issue_rob_id, 0);
    check("rst_commit_rd", bus.commit_rd, 0);

    // In-order commit with out-of-order writeback
    for (int k = 1; k <= 3; k++) begin
      set_issue(2'd0, 5'(k), 1'b0, 32'd0);
      check("io_issue_id", bus.issue_rob_id, 32'(k - 1));
      tick();
    end
    idle();
    set_alu(4'd2, 32'h22, 1'b0); tick();
    set_alu(4'd0, 32'h20, 1'b0); tick();
    check("io_no_same_cycle_retire", bus.commit_valid, 0);
    set_alu(4'd1, 32'h21, 1'b0); tick();
    idle();
    check("io_c0_valid", bus.commit_valid, 1);
    check("io_c0_rd", bus.commit_rd, 1);
    check("io_c0_value", bus.commit_value, 32'h20);
    check("io_c0_id", bus.commit_rob_id, 0);
    tick();
    check("io_c1_valid", bus.commit_valid, 1);
    check("io_c1_rd", bus.commit_rd, 2);
    check("io_c1_value", bus.commit_value, 32'h21);
    check("io_c1_id", bus.commit_rob_id, 1);
    tick();
    check("io_c2_valid", bus.commit_valid, 1);
    check("io_c2_rd", bus.commit_rd, 3);
    check("io_c2_value", bus.commit_value, 32'h22);
    check("io_c2_id", bus.commit_rob_id, 2);
    tick();
    check("io_pulse_end", bus.commit_valid, 0);
    check("io_count", dut.count, 0);

    // Fill to full, overflow issue ignored, issue+retire while full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
      tick();
    end
    check("full_flag", bus.rob_full, 1);
    check("full_tail_wrapped", bus.issue_rob_id, 0);
    set_issue(2'd0, 5'd31, 1'b0, 32'd0);
    tick();
    check("full_overflow_full", bus.rob_full, 1);
    check("full_overflow_tail", bus.issue_rob_id, 0);
    check("full_overflow_count", dut.count, 16);
    idle();
    set_alu(4'd0, 32'h55, 1'b0); tick();
    idle();
    set_issue(2'd0, 5'd7, 1'b0, 32'd0);
    tick();
    idle();
    check("full_swap_count", dut.count, 16);
    check("full_swap_full", bus.rob_full, 1);
    check("full_swap_tail", bus.issue_rob_id, 1);
    check("full_swap_commit", bus.commit_valid, 1);
    check("full_swap_rd", bus.commit_rd, 1);
    check("full_swap_value", bus.commit_value, 32'h55);
    tick();
    check("full_hold_commit", bus.commit_valid, 0);
    check("full_hold_count", dut.count, 16);

    // Mispredicted branch flushes younger entries
    do_reset();
    set_issue(2'd2, 5'd0, 1'b0, 32'h100); tick();
    set_issue(2'd0, 5'd5, 1'b0, 32'd0); tick();
    set_issue(2'd0, 5'd6, 1'b0, 32'd0); tick();
    idle();
    set_alu(4'd0, 32'd0, 1'b1);
    set_lsb(4'd1, 32'h77);
    tick();
    idle();
    set_issue(2'd0, 5'd9, 1'b0, 32'd0);
    tick();
    idle();
    check("mp_flush", bus.flush, 1);
    check("mp_flush_pc", bus.flush_pc, 32'h100);
    check("mp_commit_valid", bus.commit_valid, 0);
    check("mp_store", bus.store_commit, 0);
    check("mp_count", dut.count, 0);
    check("mp_tail", bus.issue_rob_id, 0);
    bus.q1_id = 4'd1;
    tick();
    check("mp_flush_end", bus.flush, 0);
    check("mp_no_young_commit", bus.commit_valid, 0);
    check("mp_lookup_cleared", bus.q1_ready, 0);
    tick();
    check("mp_no_young_commit2", bus.commit_valid, 0);

    // Store, correct branch, reserved type behaves as reg write
    do_reset();
    set_issue(2'd1, 5'd0, 1'b0, 32'd0); tick();
    set_issue(2'd2, 5'd0, 1'b1, 32'h200); tick();
    set_issue(2'd3, 5'd4, 1'b0, 32'd0); tick();
    idle();
    set_lsb(4'd0, 32'd0);
    set_alu(4'd1, 32'd0, 1'b1);
    tick();
    idle();
    set_alu(4'd2, 32'h44, 1'b0);
    tick();
    idle();
    check("st_store_commit", bus.store_commit, 1);
    check("st_commit_valid", bus.commit_valid, 0);
    check("st_commit_id", bus.commit_rob_id, 0);
    tick();
    check("br_ok_flush", bus.flush, 0);
    check("br_ok_store", bus.store_commit, 0);
    check("br_ok_commit", bus.commit_valid, 0);
    tick();
    check("t3_commit_valid", bus.commit_valid, 1);
    check("t3_commit_rd", bus.commit_rd, 4);
    check("t3_commit_value", bus.commit_value, 32'h44);

    // Same-id alu/lsb collision and lookup forwarding
    do_reset();
    set_issue(2'd0, 5'd1, 1'b0, 32'd0); tick();
    set_issue(2'd0, 5'd2, 1'b0, 32'd0); tick();
    idle();
    set_alu(4'd1, 32'hAAAA, 1'b0);
    set_lsb(4'd1, 32'hBBBB);
    bus.q1_id = 4'd1;
    bus.q2_id = 4'd0;
    #1;
    check("fw_q1_ready", bus.q1_ready, 1);
    check("fw_q1_value", bus.q1_value, 32'hBBBB);
    check("fw_q2_ready", bus.q2_ready, 0);
    check("fw_q2_value", bus.q2_value, 0);
    tick();
    idle();
    bus.q1_id = 4'd1;
    bus.q2_id = 4'd0;
    set_alu(4'd0, 32'h1234, 1'b0);
    #1;
    check("st_q1_stored", bus.q1_value, 32'hBBBB);
    check("fw_q2_alu_ready", bus.q2_ready, 1);
    check("fw_q2_alu_value", bus.q2_value, 32'h1234);
    tick();
    idle();
    tick();
    check("fw_c0_value", bus.commit_value, 32'h1234);
    tick();
    check("fw_c1_rd", bus.commit_rd, 2);
    check("fw_c1_value", bus.commit_value, 32'hBBBB);

    // rdy low freezes state; rst mid-stream discards entries
    do_reset();
    set_issue(2'd0, 5'd3, 1'b0, 32'd0); tick();
    set_issue(2'd0, 5'd4, 1'b0, 32'd0); tick();
    idle();
    set_alu(4'd0, 32'h99, 1'b0); tick();
    idle();
    bus.rdy = 1'b0;
    set_issue(2'd0, 5'd8, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rdy_no_commit", bus.commit_valid, 0);
      check("rdy_tail_frozen", bus.issue_rob_id, 2);
    end
    idle();
    tick();
    check("rdy_resume_commit", bus.commit_valid, 1);
    check("rdy_resume_rd", bus.commit_rd, 3);
    check("rdy_resume_value", bus.commit_value, 32'h99);
    check("rdy_resume_tail", bus.issue_rob_id, 2);
    bus.rdy = 1'b0;
    tick();
    check("rdy_pulse_drop", bus.commit_valid, 0);
    idle();
    set_issue(2'd0, 5'd9, 1'b0, 32'd0);
    set_alu(4'd1, 32'h5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("mrst_commit_valid", bus.commit_valid, 0);
    check("mrst_commit_rd", bus.commit_rd, 0);
    check("mrst_commit_value", bus.commit_value, 0);
    check("mrst_flush", bus.flush, 0);
    check("mrst_rob_full", bus.rob_full, 0);
    check("mrst_tail", bus.issue_rob_id, 0);
    tick();
    check("mrst_discarded", bus.commit_valid, 0);
    check("mrst_count", dut.count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
